uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among NREQ byte producers. It sits between client blocks (command responder, status reporter, debug echo of received bytes) and the transmitter. It sequences one byte at a time: start pulse, then wait for the transmitter's done tick. A requester holding `lock` keeps the grant for a bounded burst, so multi-byte messages are not interleaved.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `MAX_BURST`, 16, max consecutive bytes one requester may send under `lock` before forced rotation (≥1)
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester byte-valid; held until own `ack`
- `lock`  in  NREQ  per-requester "more bytes follow, keep grant"
- `din`  in  8*NREQ  requester i byte on `din[8*i+7:8*i]`
- `ack`  out  NREQ  one-cycle pulse: requester's byte captured, `din` may change
- `grant`  out  NREQ  one-hot current owner, all-zero when idle
- `tx_start`  out  1  one-cycle start pulse to transmitter
- `tx_din`  out  8  byte to transmitter, valid while `tx_start`=1 and held until next load
- `tx_done_tick`  in  1  transmitter end-of-stop-bit pulse
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, WAIT.
- IDLE: if `req`≠0, pick the winner by round-robin starting at `ptr`. Searched order: `ptr`, `ptr+1`, … mod NREQ. On the same edge, latch `din[winner]` into `tx_din`, set `grant`, clear `burst_cnt`, and go to LOAD.
- LOAD: lasts 1 cycle. `tx_start`=1 and `ack[g]`=1 in this cycle. Then go to WAIT.
- WAIT: hold `grant`, `tx_din`. On `tx_done_tick`, `burst_cnt` increments:
  - if `lock[g]` & `req[g]` & `burst_cnt+1 < MAX_BURST`: latch `din[g]`, go to LOAD with the same grant;
  - else: `ptr` = g+1 mod NREQ, `grant`=0, go to IDLE.
- `tx_done_tick` in IDLE or LOAD is ignored.
- `req`/`lock` of non-granted requesters are ignored until IDLE.
- `lock` without `req` at done tick releases the grant.
- Dropping `req[g]` after capture does not cancel the byte. It is still transmitted.
- Widths: `ptr` is $clog2(NREQ) bits, with explicit wrap at NREQ when NREQ is not a power of 2. `burst_cnt` is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
- Reset values: all outputs 0, state IDLE, `ptr`=0, `burst_cnt`=0, `tx_din`=0.
- Reset mid-byte aborts immediately. No `ack` is re-issued, and the transmitter must be reset by the same `rstn`.

## Timing
- `req[i]` sampled high at edge k in IDLE (i wins): `grant` and `tx_din` are valid after edge k. `tx_start` and `ack[i]` are high for exactly cycle k→k+1.
- `tx_done_tick` at edge m with burst continue: `tx_start` high for cycle m→m+1. Gap between bytes is 1 clk.
- `tx_done_tick` at edge m with release: IDLE from m. The next grant is decided at edge m+1, and `tx_start` is high for cycle m+1→m+2.
- At most one `tx_start` per `tx_done_tick`. `tx_start` is never asserted in WAIT.
- `ack` is never asserted for a non-granted requester. `popcount(grant)` ≤ 1 always.

## Structure
- Shared package `uart_pkg`: state encodings (ARB_IDLE, ARB_LOAD, ARB_WAIT) and DATA_W=8 (used by Receiver/transmitter too).
- Sub-module `uart_rr_pick`: combinational, inputs `req`, `ptr`, outputs one-hot `pick` and index. Instantiated once; reusable for other shared UART resources.

## Test plan
- Single requester: `req`=0001, `din[0]`=0x55, done tick after 160 cycles → one `tx_start` with `tx_din`=0x55, `ack[0]` in the same cycle, `busy` low 1 cycle after tick.
- Rotation: `req`=1111 held, `lock`=0, bytes 0xA0..0xA3 → transmit order 0,1,2,3,0 and `ptr` wraps 3→0.
- Burst: `lock[2]`=1, `req`=0110, MAX_BURST=4, requester 2 supplies 0x10..0x15 → 0x10..0x13 sent back-to-back, then requester 1's byte, then 0x14.
- Lock release: `lock[1]`=1 but `req[1]` dropped before done tick → grant released, IDLE next cycle, no extra `tx_start`.
- Spurious tick: `tx_done_tick` in IDLE and in LOAD → no state change, no `ack`.
- Reset mid-WAIT: assert `rstn`=0 during WAIT → all outputs 0 asynchronously. After release, `req`=1000 is granted first (`ptr`=0 searches 0..3).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX arbiter state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping at N.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int slot;

  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    slot    = 0;
    for (int off = 0; off < N; off++) begin
      slot = int'(ptr_i) + off;
      if (slot >= N) slot = slot - N;
      if (!valid_o && req_i[slot]) begin
        valid_o      = 1'b1;
        pick_o[slot] = 1'b1;
        idx_o        = IW'(slot);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte producers,
// one byte per start/done handshake, with bounded lock bursts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        lock_i,
  input  logic [DATA_W*NREQ-1:0] din_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [NREQ-1:0]        grant_o,
  output logic                   tx_start_o,
  output logic [DATA_W-1:0]      tx_din_o,
  input  logic                   tx_done_tick_i,
  output logic                   busy_o,
  output arb_state_e             state_o
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [DATA_W-1:0] tx_din_q, tx_din_d;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [BW:0]     burst_inc;

  uart_rr_pick #(.N(NREQ), .IW(PW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      tx_din_q <= tx_din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    tx_din_d  = tx_din_q;
    burst_inc = {1'b0, burst_q} + (BW+1)'(1);
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick;
          gidx_d   = pick_idx;
          tx_din_d = din_i[DATA_W*pick_idx +: DATA_W];
          burst_d  = '0;
          state_d  = ARB_LOAD;
        end
      end
      ARB_LOAD: state_d = ARB_WAIT;
      ARB_WAIT: begin
        // Only the owner's req/lock matter; everyone else waits for IDLE.
        if (tx_done_tick_i) begin
          burst_d = burst_inc[BW-1:0];
          if (lock_i[gidx_q] && req_i[gidx_q] && (burst_inc < (BW+1)'(MAX_BURST))) begin
            tx_din_d = din_i[DATA_W*gidx_q +: DATA_W];
            state_d  = ARB_LOAD;
          end else begin
            ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Handshake: tx_start and ack[g] pulse together for the single LOAD cycle;
  // tx_din and grant stay stable from capture until the next load or release.
  assign tx_start_o = (state_q == ARB_LOAD);
  assign ack_o      = tx_start_o ? grant_q : '0;
  assign grant_o    = grant_q;
  assign tx_din_o   = tx_din_q;
  assign busy_o     = (state_q != ARB_IDLE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester/transmitter models, scheduling reference, directed scenarios.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int W         = 2 + NREQ + DATA_W;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic [NREQ-1:0]        req, lock, ack, grant;
  logic [DATA_W*NREQ-1:0] din;
  logic                   tx_start, tx_done_tick, busy;
  logic [DATA_W-1:0]      tx_din;
  arb_state_e             state;

  logic                   man_mode = 1'b1;
  logic [NREQ-1:0]        man_req  = '0;
  logic [NREQ-1:0]        man_lock = '0;
  logic [DATA_W*NREQ-1:0] man_din  = '0;
  logic                   man_tick = 1'b0;
  logic                   auto_en  = 1'b0;
  logic                   auto_tick = 1'b0;
  int                     auto_cnt = 0;
  int                     lat_lo = 2, lat_hi = 6;

  logic [7:0]      src_mem [NREQ][32];
  int              src_len [NREQ];
  int              src_head[NREQ];
  logic [NREQ-1:0] lock_en = '0;

  int checks = 0, errors = 0;
  int ptr_m = 0;
  int edge_n = 0, last_tick_edge = -1000;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_i          (req),
    .lock_i         (lock),
    .din_i          (din),
    .ack_o          (ack),
    .grant_o        (grant),
    .tx_start_o     (tx_start),
    .tx_din_o       (tx_din),
    .tx_done_tick_i (tx_done_tick),
    .busy_o         (busy),
    .state_o        (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (tx_done_tick) last_tick_edge = edge_n;
  end

  // ---------------- requester and transmitter models ----------------
  always_comb begin
    req  = man_req;
    lock = man_lock;
    din  = man_din;
    if (!man_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i]        = (src_head[i] < src_len[i]);
        din[8*i +: 8] = src_mem[i][src_head[i]];
        lock[i]       = lock_en[i];
      end
    end
  end

  always @(negedge clk) begin
    if (!auto_en) begin
      auto_tick = 1'b0;
      auto_cnt  = 0;
    end else begin
      auto_tick = 1'b0;
      if (auto_cnt > 0) begin
        auto_cnt = auto_cnt - 1;
        if (auto_cnt == 0) auto_tick = 1'b1;
      end
      if (tx_start) auto_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
    end
  end

  assign tx_done_tick = man_tick | auto_tick;

  // ---------------- reference helpers ----------------
  function automatic int rr_win(logic [NREQ-1:0] r, int p);
    int best = NREQ;
    int w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && ((i - p + NREQ) % NREQ) < best) begin
        best = (i - p + NREQ) % NREQ;
        w = i;
      end
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick_cycle();
    logic [NREQ-1:0] exp_ack;
    int gap;
    logic [1:0] code;
    @(negedge clk);
    exp_ack = tx_start ? grant : '0;
    checks++;
    if ($countones(grant) > 1) begin
      errors++; $display("FAIL grant_onehot: got %b required popcount<=1", grant);
    end
    checks++;
    if (ack !== exp_ack) begin
      errors++; $display("FAIL ack_vs_grant: got %b expected %b", ack, exp_ack);
    end
    if (tx_start) begin
      checks++;
      if (grant == '0 || state == ARB_WAIT) begin
        errors++; $display("FAIL start_owner: got grant %b state %0d expected owner outside WAIT", grant, state);
      end
      gap  = edge_n - last_tick_edge;
      code = (gap == 0) ? 2'd0 : ((gap == 1) ? 2'd1 : 2'd2);
      obs_q.push_back({code, grant, tx_din});
    end
    if (!man_mode) begin
      for (int i = 0; i < NREQ; i++)
        if (ack[i] && src_head[i] < src_len[i]) src_head[i] = src_head[i] + 1;
    end
  endtask

  task automatic pulse_tick();
    man_tick = 1'b1;
    tick_cycle();
    man_tick = 1'b0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin
      src_len[i]  = 0;
      src_head[i] = 0;
    end
    lock_en = '0;
  endtask

  // Predicts the full transmit schedule from the loaded queues, then runs it.
  task automatic run_batch(input string name);
    int rem[NREQ];
    int pos[NREQ];
    int p, w, n, budget;
    bit first;
    logic [NREQ-1:0] r;
    logic [1:0] code;
    exp_q.delete();
    obs_q.delete();
    p = ptr_m;
    first = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = src_len[i];
      pos[i] = 0;
    end
    forever begin
      for (int i = 0; i < NREQ; i++) r[i] = (rem[i] > 0);
      if (r == '0) break;
      w = rr_win(r, p);
      n = 0;
      do begin
        code = first ? 2'd2 : ((n == 0) ? 2'd1 : 2'd0);
        exp_q.push_back({code, onehot(w), src_mem[w][pos[w]]});
        pos[w]++; rem[w]--; n++; first = 1'b0;
      end while (lock_en[w] && rem[w] > 0 && n < MAX_BURST);
      p = (w + 1) % NREQ;
    end
    ptr_m = p;
    auto_en  = 1'b1;
    man_mode = 1'b0;
    budget = 0;
    while (!((obs_q.size() >= exp_q.size()) && !busy) && budget < 3000) begin
      tick_cycle();
      budget++;
    end
    if (budget >= 3000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", name, obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s byte %0d: got gap/grant/data %h expected %h", name, k, obs_q[k], exp_q[k]);
      end
    end
    man_mode = 1'b1;
    man_req  = '0;
    man_lock = '0;
    auto_en  = 1'b0;
    repeat (3) tick_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    man_req = '1;
    #1 rstn = 1'b0;
    repeat (2) tick_cycle();
    checks++; if (grant !== '0)    begin errors++; $display("FAIL rst_grant: got %b expected 0", grant); end
    checks++; if (ack !== '0)      begin errors++; $display("FAIL rst_ack: got %b expected 0", ack); end
    checks++; if (tx_start !== 0)  begin errors++; $display("FAIL rst_start: got %b expected 0", tx_start); end
    checks++; if (tx_din !== '0)   begin errors++; $display("FAIL rst_txdin: got %h expected 0", tx_din); end
    checks++; if (busy !== 0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (state !== ARB_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected IDLE", state); end
    man_req = '0;
    rstn = 1'b1;
    repeat (2) tick_cycle();
    ptr_m = 0;
    clear_src();
  endtask

  task automatic test_rotation();
    clear_src();
    src_len[0] = 2; src_mem[0][0] = 8'hA0; src_mem[0][1] = 8'hA4;
    for (int i = 1; i < NREQ; i++) begin
      src_len[i] = 1;
      src_mem[i][0] = 8'hA0 + 8'(i);
    end
    run_batch("rotation");
  endtask

  task automatic test_single();
    obs_q.delete();
    man_din = $urandom;
    man_din[7:0] = 8'h55;
    man_lock = '0;
    man_req = 4'b0001;
    @(posedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", tx_start); end
    checks++; if (ack !== 4'b0001)   begin errors++; $display("FAIL single_ack: got %b expected 0001", ack); end
    checks++; if (tx_din !== 8'h55)  begin errors++; $display("FAIL single_txdin: got %h expected 55", tx_din); end
    tick_cycle();
    man_req = '0;
    man_din = $urandom;
    repeat (159) tick_cycle();
    checks++; if (state !== ARB_WAIT || tx_din !== 8'h55) begin
      errors++; $display("FAIL single_hold: got state %0d data %h expected WAIT 55", state, tx_din);
    end
    man_tick = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL single_release: got busy %b grant %b expected 0 0", busy, grant);
    end
    tick_cycle();
    man_tick = 1'b0;
    repeat (3) tick_cycle();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
    ptr_m = 1;
  endtask

  task automatic test_burst();
    clear_src();
    src_len[1] = 1; src_mem[1][0] = 8'h77;
    run_batch("burst_prep");
    clear_src();
    src_len[1] = 1; src_mem[1][0] = 8'h99;
    src_len[2] = 6;
    for (int k = 0; k < 6; k++) src_mem[2][k] = 8'h10 + 8'(k);
    lock_en = 4'b0100;
    run_batch("burst");
  endtask

  task automatic test_lock_release();
    logic [NREQ-1:0] r;
    int w;
    obs_q.delete();
    man_din = $urandom;
    man_din[15:8] = 8'h3C;
    man_req  = 4'b0010;
    man_lock = 4'b0010;
    tick_cycle();
    man_req = '0;
    repeat (4) tick_cycle();
    man_tick = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || grant !== '0 || state !== ARB_IDLE) begin
      errors++; $display("FAIL lockrel_release: got busy %b grant %b state %0d expected idle", busy, grant, state);
    end
    tick_cycle();
    man_tick = 1'b0;
    repeat (4) tick_cycle();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL lockrel_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0][NREQ+7:0] !== {4'b0010, 8'h3C}) begin
        errors++; $display("FAIL lockrel_byte: got %h expected %h", obs_q[0][NREQ+7:0], {4'b0010, 8'h3C});
      end
    end
    ptr_m = 2;
    man_lock = '0;
    r = 4'($urandom_range(1, 15));
    w = rr_win(r, ptr_m);
    man_req = r;
    @(posedge clk); #1;
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL lockrel_next: got %b expected %b", grant, onehot(w)); end
    tick_cycle();
    man_req = '0;
    repeat (2) tick_cycle();
    pulse_tick();
    repeat (2) tick_cycle();
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic test_spurious_tick();
    int w;
    obs_q.delete();
    man_req = '0;
    pulse_tick();
    checks++; if (state !== ARB_IDLE || busy !== 1'b0 || ack !== '0) begin
      errors++; $display("FAIL spur_idle: got state %0d busy %b ack %b expected idle", state, busy, ack);
    end
    w = $urandom_range(0, NREQ-1);
    man_din = $urandom;
    man_req = onehot(w);
    @(posedge clk); #1;
    checks++; if (state !== ARB_LOAD) begin errors++; $display("FAIL spur_load: got %0d expected LOAD", state); end
    man_tick = 1'b1;
    tick_cycle();
    man_req = '0;
    @(posedge clk); #1;
    checks++; if (state !== ARB_WAIT || grant !== onehot(w) || tx_start !== 1'b0) begin
      errors++; $display("FAIL spur_in_load: got state %0d grant %b start %b expected WAIT %b 0", state, grant, tx_start, onehot(w));
    end
    man_tick = 1'b0;
    repeat (3) tick_cycle();
    checks++; if (state !== ARB_WAIT) begin errors++; $display("FAIL spur_wait: got %0d expected WAIT", state); end
    pulse_tick();
    tick_cycle();
    checks++; if (state !== ARB_IDLE || obs_q.size() != 1) begin
      errors++; $display("FAIL spur_end: got state %0d starts %0d expected IDLE 1", state, obs_q.size());
    end
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic test_random();
    int tot;
    for (int b = 0; b < 8; b++) begin
      clear_src();
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        src_len[i] = $urandom_range(0, 6);
        tot += src_len[i];
        for (int k = 0; k < src_len[i]; k++) src_mem[i][k] = 8'($urandom);
      end
      if (tot == 0) begin src_len[0] = 1; src_mem[0][0] = 8'($urandom); end
      lock_en = 4'($urandom);
      lat_lo = 2;
      lat_hi = $urandom_range(2, 10);
      run_batch($sformatf("random%0d", b));
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    man_din = $urandom;
    man_din[23:16] = 8'hC3;
    man_req = 4'b0100;
    tick_cycle();
    man_req = '0;
    repeat (3) tick_cycle();
    #2 rstn = 1'b0;
    #1;
    checks++; if (grant !== '0)   begin errors++; $display("FAIL midrst_grant: got %b expected 0", grant); end
    checks++; if (tx_din !== '0)  begin errors++; $display("FAIL midrst_txdin: got %h expected 0", tx_din); end
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== '0 || state !== ARB_IDLE) begin
      errors++; $display("FAIL midrst_outs: got busy %b start %b ack %b state %0d expected all 0", busy, tx_start, ack, state);
    end
    repeat (2) tick_cycle();
    rstn = 1'b1;
    ptr_m = 0;
    tick_cycle();
    man_req = 4'b1010;
    w = rr_win(man_req, ptr_m);
    @(posedge clk); #1;
    checks++; if (grant !== onehot(w) || tx_din !== man_din[8*w +: 8]) begin
      errors++; $display("FAIL midrst_first: got grant %b data %h expected %b %h", grant, tx_din, onehot(w), man_din[8*w +: 8]);
    end
    tick_cycle();
    man_req = '0;
    repeat (2) tick_cycle();
    pulse_tick();
    repeat (2) tick_cycle();
    ptr_m = (w + 1) % NREQ;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_src();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 32; k++) src_mem[i][k] = '0;
    test_reset();
    test_rotation();
    test_single();
    test_burst();
    test_lock_release();
    test_spurious_tick();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
